rvfi_bus_dmem_window_check: RTL and testbench
=============================================

Name: rvfi_bus_dmem_window_check

Overview:
- Multi-channel data-memory consistency checker between the external bus RVFI stream and the retired-instruction RVFI stream.
- Tracks a window of DEPTH consecutive words.
  - Bus side keeps a byte shadow that constrains bus read data.
  - Core side keeps a byte shadow that checks retired load data, including misaligned accesses.
- Sits beside the core in formal and simulation harnesses; reports a sticky error with a capture of the first failure.

Parameters:
- XLEN, 32, core word width in bits.
- BUSLEN, 32, bus beat width in bits; multiple of 8.
- NBUS, 1, number of bus RVFI channels.
- NRET, 1, number of retire channels.
- DEPTH, 4, words in the tracked window; power of two, 1..16.

Ports:
- clock  in  1  sole clock.
- reset  in  1  asynchronous, active-high reset.
- check  in  1  enables core-side comparisons this cycle.
- win_base  in  XLEN  window base; low log2(XLEN/8) bits ignored; held constant by harness.
- init_data  in  XLEN  initial content, replicated into every window word at reset.
- rvfi_bus_valid  in  NBUS  bus beat valid per channel.
- rvfi_bus_data  in  NBUS  beat is a data (not instruction) access.
- rvfi_bus_addr  in  NBUS*XLEN  beat byte address.
- rvfi_bus_rmask, rvfi_bus_wmask  in  NBUS*BUSLEN/8  byte masks.
- rvfi_bus_rdata, rvfi_bus_wdata  in  NBUS*BUSLEN  beat data.
- rvfi_valid  in  NRET  retire valid.
- rvfi_mem_addr  in  NRET*XLEN  access byte address.
- rvfi_mem_rmask, rvfi_mem_wmask  in  NRET*XLEN/8  byte masks.
- rvfi_mem_rdata, rvfi_mem_wdata  in  NRET*XLEN  data.
- env_ok  out  1  combinational; 0 when a bus read byte disagrees with the bus shadow; harness assumes env_ok.
- err  out  1  sticky core-side mismatch.
- err_chan  out  4  retire channel of first error.
- err_addr  out  XLEN  byte address of first error.
- chk_count  out  16  saturating count of compared bytes.
- cover_hit  out  1  pulses high for one cycle after any comparison occurs.

Behaviour:
- Window membership: byte address a is in window iff (a - base_aligned) mod 2^XLEN < DEPTH*XLEN/8. Base wrap-around is legal.
- Reset (async): both shadows <- init_data per word; state = INIT; err = 0; err_chan = 0; err_addr = 0; chk_count = 0; cover_hit = 0.
- FSM:
  - INIT -> RUN on the first clock after reset deasserts; no checks or updates occur in INIT.
  - RUN -> FAIL on the first core mismatch.
  - FAIL is sticky until reset; shadows, count and capture are frozen in FAIL.
- Bus side (RUN), per cycle:
  - Channels are processed in ascending index.
  - For each valid data beat, bytes are processed i = 0..BUSLEN/8-1 at address addr+i.
  - Read byte in window: env_ok = 0 if rdata byte != bus shadow byte.
  - Write byte in window: bus shadow byte <- wdata byte. Visible to later bytes and channels in the same cycle.
- Core side (RUN), per cycle:
  - Channels are processed in ascending index.
  - For each byte j with mem_addr+j in window, use that channel's own rdata/wdata slice.
  - If check && rmask[j]: compare core shadow to the rdata byte.
    - Increment chk_count, saturating at 0xFFFF.
    - Set cover_hit next cycle.
    - On mismatch, and only if this is the first error: err <= 1, capture channel and byte address, go to FAIL.
  - Then, if wmask[j]: core shadow byte <- wdata byte. Read-before-write within a byte.
- Simultaneous mismatches in one cycle: lowest channel, then lowest byte, is captured.
- Out-of-window bytes are ignored on both sides.
- Asserting reset mid-run restores all reset values immediately.

Optional Feature:
- Macro RISCV_FORMAL_BUS_DMEM_WRCHK_EN.
- Defined: each in-window bus write byte (RUN) is also compared against the core shadow as updated this cycle.
  - A mismatch sets err exactly as a core error does, with err_chan = 4'hF.
- Undefined: bus writes only update the bus shadow; no write-propagation check.

Test Plan (XLEN=32, BUSLEN=32, NBUS=1, NRET=2, DEPTH=4, win_base=0x1000, init_data=0xA5A5A5A5):
- Reset, then a channel-0 load at 0x1004 with rmask=0xF, rdata=0xA5A5A5A5, check=1 -> err=0, chk_count=4, cover_hit pulses.
- Bus read at 0x1008 with rdata=0x00000000 -> env_ok=0 that cycle. The same read with rdata=0xA5A5A5A5 -> env_ok=1.
- Channel-0 store of 0x11223344 to 0x100C; next cycle a channel-1 load at 0x100E (misaligned, rmask=0xF) returns 0xA5A51122 -> no error (bytes at 0x1010 and above are out of window, not compared), chk_count += 2.
- Same cycle: channel 0 loads 0x1000 with a bad byte 1, channel 1 loads 0x1004 bad -> err=1, err_chan=0, err_addr=0x1001. Later mismatches leave the capture unchanged.
- Assert reset while in FAIL -> err=0 and chk_count=0 asynchronously; a load of 0x1000 expecting 0xA5A5A5A5 passes.
- With WRCHK_EN: core stores 0xDEADBEEF to 0x1000, bus writes 0xDEADBEE0 to 0x1000 -> err=1, err_chan=0xF, err_addr=0x1000.

Source files
------------

// File: rtl/rvfi_bus_dmem_window_check_if.sv
// Bundle of the bus-side and retire-side RVFI memory signals observed by
// rvfi_bus_dmem_window_check. The harness/core side drives through
// "master"; the checker listens through "slave".
interface rvfi_bus_dmem_window_check_if #(
    parameter int XLEN   = 32,
    parameter int BUSLEN = 32,
    parameter int NBUS   = 1,
    parameter int NRET   = 1
);
    logic [NBUS-1:0]          rvfi_bus_valid;
    logic [NBUS-1:0]          rvfi_bus_data;
    logic [NBUS*XLEN-1:0]     rvfi_bus_addr;
    logic [NBUS*BUSLEN/8-1:0] rvfi_bus_rmask;
    logic [NBUS*BUSLEN/8-1:0] rvfi_bus_wmask;
    logic [NBUS*BUSLEN-1:0]   rvfi_bus_rdata;
    logic [NBUS*BUSLEN-1:0]   rvfi_bus_wdata;
    logic [NRET-1:0]          rvfi_valid;
    logic [NRET*XLEN-1:0]     rvfi_mem_addr;
    logic [NRET*XLEN/8-1:0]   rvfi_mem_rmask;
    logic [NRET*XLEN/8-1:0]   rvfi_mem_wmask;
    logic [NRET*XLEN-1:0]     rvfi_mem_rdata;
    logic [NRET*XLEN-1:0]     rvfi_mem_wdata;

    modport master (
        output rvfi_bus_valid, rvfi_bus_data, rvfi_bus_addr,
        output rvfi_bus_rmask, rvfi_bus_wmask, rvfi_bus_rdata, rvfi_bus_wdata,
        output rvfi_valid, rvfi_mem_addr, rvfi_mem_rmask, rvfi_mem_wmask,
        output rvfi_mem_rdata, rvfi_mem_wdata
    );

    modport slave (
        input rvfi_bus_valid, rvfi_bus_data, rvfi_bus_addr,
        input rvfi_bus_rmask, rvfi_bus_wmask, rvfi_bus_rdata, rvfi_bus_wdata,
        input rvfi_valid, rvfi_mem_addr, rvfi_mem_rmask, rvfi_mem_wmask,
        input rvfi_mem_rdata, rvfi_mem_wdata
    );
endinterface

// File: rtl/rvfi_bus_dmem_window_check.sv
// Data-memory consistency checker between the bus RVFI stream and the
// retired-instruction RVFI stream over a window of DEPTH words.
// The bus shadow constrains bus read data (env_ok); the core shadow checks
// retired load data and latches the first mismatch.
// Optional macro RISCV_FORMAL_BUS_DMEM_WRCHK_EN: also compare every in-window
// bus write byte against the core shadow (error channel reported as 4'hF).
module rvfi_bus_dmem_window_check #(
    parameter int XLEN   = 32,
    parameter int BUSLEN = 32,
    parameter int NBUS   = 1,
    parameter int NRET   = 1,
    parameter int DEPTH  = 4
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            check,
    input  logic [XLEN-1:0] win_base,
    input  logic [XLEN-1:0] init_data,
    rvfi_bus_dmem_window_check_if.slave rvfi,
    output logic            env_ok,
    output logic            err,
    output logic [3:0]      err_chan,
    output logic [XLEN-1:0] err_addr,
    output logic [15:0]     chk_count,
    output logic            cover_hit
);
    localparam int WB = XLEN / 8;      // bytes per core word
    localparam int BB = BUSLEN / 8;    // bytes per bus beat
    localparam int NB = DEPTH * WB;    // bytes in the window
    localparam int IW = (NB > 1) ? $clog2(NB) : 1;
    localparam logic [XLEN-1:0] LOW_MASK = XLEN'(WB - 1);

    localparam logic [1:0] ST_INIT = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_FAIL = 2'd2;

    logic [1:0]      state_reg;
    logic [7:0]      bus_shadow_reg [NB];
    logic [7:0]      bus_shadow_next [NB];
    logic [7:0]      core_shadow_reg [NB];
    logic [7:0]      core_shadow_next [NB];
    logic            err_reg;
    logic [3:0]      err_chan_reg;
    logic [XLEN-1:0] err_addr_reg;
    logic [15:0]     chk_count_reg;
    logic [15:0]     chk_count_next;
    logic            cover_hit_reg;
    logic            cover_hit_next;
    logic            mism_next;
    logic [3:0]      mism_chan_next;
    logic [XLEN-1:0] mism_addr_next;
    logic [XLEN-1:0] base_aligned;
    logic [XLEN-1:0] bus_off;
    logic [XLEN-1:0] core_off;
    logic [XLEN-1:0] core_byte_addr;

    // Per-channel views of the flat RVFI vectors.
    logic [XLEN-1:0]   bus_addr_ch  [NBUS];
    logic [BB-1:0]     bus_rmask_ch [NBUS];
    logic [BB-1:0]     bus_wmask_ch [NBUS];
    logic [BUSLEN-1:0] bus_rdata_ch [NBUS];
    logic [BUSLEN-1:0] bus_wdata_ch [NBUS];
    logic [XLEN-1:0]   ret_addr_ch  [NRET];
    logic [WB-1:0]     ret_rmask_ch [NRET];
    logic [WB-1:0]     ret_wmask_ch [NRET];
    logic [XLEN-1:0]   ret_rdata_ch [NRET];
    logic [XLEN-1:0]   ret_wdata_ch [NRET];

    genvar gi;
    generate
        for (gi = 0; gi < NBUS; gi++) begin : g_bus_ch
            assign bus_addr_ch[gi]  = rvfi.rvfi_bus_addr[gi*XLEN +: XLEN];
            assign bus_rmask_ch[gi] = rvfi.rvfi_bus_rmask[gi*BB +: BB];
            assign bus_wmask_ch[gi] = rvfi.rvfi_bus_wmask[gi*BB +: BB];
            assign bus_rdata_ch[gi] = rvfi.rvfi_bus_rdata[gi*BUSLEN +: BUSLEN];
            assign bus_wdata_ch[gi] = rvfi.rvfi_bus_wdata[gi*BUSLEN +: BUSLEN];
        end
        for (gi = 0; gi < NRET; gi++) begin : g_ret_ch
            assign ret_addr_ch[gi]  = rvfi.rvfi_mem_addr[gi*XLEN +: XLEN];
            assign ret_rmask_ch[gi] = rvfi.rvfi_mem_rmask[gi*WB +: WB];
            assign ret_wmask_ch[gi] = rvfi.rvfi_mem_wmask[gi*WB +: WB];
            assign ret_rdata_ch[gi] = rvfi.rvfi_mem_rdata[gi*XLEN +: XLEN];
            assign ret_wdata_ch[gi] = rvfi.rvfi_mem_wdata[gi*XLEN +: XLEN];
        end
    endgenerate

    // Window offsets are taken modulo 2^XLEN, so a base near the top wraps.
    assign base_aligned = win_base & ~LOW_MASK;

    // Bus side: walk channels then bytes in order, checking reads and
    // applying writes immediately so later bytes see them.
    always_comb begin
        bus_shadow_next = bus_shadow_reg;
        env_ok          = 1'b1;
        bus_off         = '0;
        if (state_reg == ST_RUN) begin
            for (int c = 0; c < NBUS; c++) begin
                for (int i = 0; i < BB; i++) begin
                    bus_off = bus_addr_ch[c] + XLEN'(i) - base_aligned;
                    if (rvfi.rvfi_bus_valid[c] && rvfi.rvfi_bus_data[c] && (bus_off < XLEN'(NB))) begin
                        if (bus_rmask_ch[c][i] &&
                            (bus_rdata_ch[c][8*i +: 8] != bus_shadow_next[bus_off[IW-1:0]]))
                            env_ok = 1'b0;
                        if (bus_wmask_ch[c][i])
                            bus_shadow_next[bus_off[IW-1:0]] = bus_wdata_ch[c][8*i +: 8];
                    end
                end
            end
        end
    end

    // Core side: read-before-write per byte, first mismatch wins by
    // channel then byte order; optional bus-write cross-check runs last.
    always_comb begin
        core_shadow_next = core_shadow_reg;
        chk_count_next   = chk_count_reg;
        cover_hit_next   = 1'b0;
        mism_next        = 1'b0;
        mism_chan_next   = 4'd0;
        mism_addr_next   = '0;
        core_off         = '0;
        core_byte_addr   = '0;
        if (state_reg == ST_RUN) begin
            for (int c = 0; c < NRET; c++) begin
                for (int j = 0; j < WB; j++) begin
                    core_byte_addr = ret_addr_ch[c] + XLEN'(j);
                    core_off       = core_byte_addr - base_aligned;
                    if (rvfi.rvfi_valid[c] && (core_off < XLEN'(NB))) begin
                        if (check && ret_rmask_ch[c][j]) begin
                            if (chk_count_next != 16'hFFFF)
                                chk_count_next = chk_count_next + 16'd1;
                            cover_hit_next = 1'b1;
                            if (!mism_next &&
                                (ret_rdata_ch[c][8*j +: 8] != core_shadow_next[core_off[IW-1:0]])) begin
                                mism_next      = 1'b1;
                                mism_chan_next = 4'(c);
                                mism_addr_next = core_byte_addr;
                            end
                        end
                        if (ret_wmask_ch[c][j])
                            core_shadow_next[core_off[IW-1:0]] = ret_wdata_ch[c][8*j +: 8];
                    end
                end
            end
`ifdef RISCV_FORMAL_BUS_DMEM_WRCHK_EN
            for (int c = 0; c < NBUS; c++) begin
                for (int i = 0; i < BB; i++) begin
                    core_byte_addr = bus_addr_ch[c] + XLEN'(i);
                    core_off       = core_byte_addr - base_aligned;
                    if (rvfi.rvfi_bus_valid[c] && rvfi.rvfi_bus_data[c] &&
                        bus_wmask_ch[c][i] && (core_off < XLEN'(NB))) begin
                        cover_hit_next = 1'b1;
                        if (!mism_next &&
                            (bus_wdata_ch[c][8*i +: 8] != core_shadow_next[core_off[IW-1:0]])) begin
                            mism_next      = 1'b1;
                            mism_chan_next = 4'hF;
                            mism_addr_next = core_byte_addr;
                        end
                    end
                end
            end
`endif
        end
    end

    // State, shadows and error capture; everything frozen outside RUN.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg     <= ST_INIT;
            err_reg       <= 1'b0;
            err_chan_reg  <= 4'd0;
            err_addr_reg  <= '0;
            chk_count_reg <= 16'd0;
            cover_hit_reg <= 1'b0;
            for (int k = 0; k < NB; k++) begin
                bus_shadow_reg[k]  <= init_data[8*(k % WB) +: 8];
                core_shadow_reg[k] <= init_data[8*(k % WB) +: 8];
            end
        end else begin
            case (state_reg)
                ST_INIT: begin
                    state_reg     <= ST_RUN;
                    cover_hit_reg <= 1'b0;
                end
                ST_RUN: begin
                    bus_shadow_reg  <= bus_shadow_next;
                    core_shadow_reg <= core_shadow_next;
                    chk_count_reg   <= chk_count_next;
                    cover_hit_reg   <= cover_hit_next;
                    if (mism_next) begin
                        err_reg      <= 1'b1;
                        err_chan_reg <= mism_chan_next;
                        err_addr_reg <= mism_addr_next;
                        state_reg    <= ST_FAIL;
                    end
                end
                default: begin
                    cover_hit_reg <= 1'b0;
                end
            endcase
        end
    end

    assign err       = err_reg;
    assign err_chan  = err_chan_reg;
    assign err_addr  = err_addr_reg;
    assign chk_count = chk_count_reg;
    assign cover_hit = cover_hit_reg;
endmodule

// File: tb/tb_rvfi_bus_dmem_window_check.sv
// Bench for rvfi_bus_dmem_window_check: directed steps followed by random
// traffic, all checked against a byte-array memory model of both shadows.
`timescale 1ns/1ps
module tb_rvfi_bus_dmem_window_check;
    localparam int XLEN = 32, BUSLEN = 32, NBUS = 1, NRET = 2, DEPTH = 4;
    localparam int NB = DEPTH * XLEN / 8;

    logic        clock = 1'b0;
    logic        reset;
    logic        check;
    logic [31:0] win_base;
    logic [31:0] init_data;
    logic        env_ok, err, cover_hit;
    logic [3:0]  err_chan;
    logic [31:0] err_addr;
    logic [15:0] chk_count;

    rvfi_bus_dmem_window_check_if #(.XLEN(XLEN), .BUSLEN(BUSLEN), .NBUS(NBUS), .NRET(NRET)) bus_if ();

    rvfi_bus_dmem_window_check #(
        .XLEN(XLEN), .BUSLEN(BUSLEN), .NBUS(NBUS), .NRET(NRET), .DEPTH(DEPTH)
    ) dut (
        .clock(clock), .reset(reset), .check(check),
        .win_base(win_base), .init_data(init_data),
        .rvfi(bus_if),
        .env_ok(env_ok), .err(err), .err_chan(err_chan), .err_addr(err_addr),
        .chk_count(chk_count), .cover_hit(cover_hit)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;
    int txn = 0;

    // Reference model: memory images indexed by byte offset from the base.
    logic [7:0]  m_bus [NB];
    logic [7:0]  m_core [NB];
    logic [7:0]  n_bus [NB];
    logic [7:0]  n_core [NB];
    bit          m_run, m_fail;
    bit          m_err, m_hit, e_env, n_mism, n_hit;
    logic [3:0]  m_chan, n_chan;
    logic [31:0] m_eaddr, n_addr;
    int          m_cnt, n_cnt;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] base_al();
        return win_base & 32'hFFFF_FFFC;
    endfunction

    function automatic bit in_win(input logic [31:0] a);
        logic [31:0] d;
        d = a - base_al();
        return d < 32'(NB);
    endfunction

    function automatic int idx(input logic [31:0] a);
        logic [31:0] d;
        d = a - base_al();
        return int'(d);
    endfunction

    task automatic model_reset();
        for (int k = 0; k < NB; k++) begin
            m_bus[k]  = init_data[8*(k%4) +: 8];
            m_core[k] = init_data[8*(k%4) +: 8];
        end
        m_run = 0; m_fail = 0; m_err = 0; m_hit = 0;
        m_chan = 0; m_eaddr = 0; m_cnt = 0;
    endtask

    // Compute what this cycle's inputs do to the memory images.
    task automatic model_eval();
        logic [31:0] a;
        n_bus = m_bus; n_core = m_core;
        e_env = 1; n_mism = 0; n_chan = 0; n_addr = 0; n_cnt = m_cnt; n_hit = 0;
        if (!m_run) return;
        for (int c = 0; c < NBUS; c++) begin
            if (bus_if.rvfi_bus_valid[c] && bus_if.rvfi_bus_data[c]) begin
                for (int i = 0; i < 4; i++) begin
                    a = bus_if.rvfi_bus_addr[c*32 +: 32] + 32'(i);
                    if (in_win(a)) begin
                        if (bus_if.rvfi_bus_rmask[c*4+i] && bus_if.rvfi_bus_rdata[c*32+8*i +: 8] != n_bus[idx(a)])
                            e_env = 0;
                        if (bus_if.rvfi_bus_wmask[c*4+i])
                            n_bus[idx(a)] = bus_if.rvfi_bus_wdata[c*32+8*i +: 8];
                    end
                end
            end
        end
        for (int r = 0; r < NRET; r++) begin
            if (bus_if.rvfi_valid[r]) begin
                for (int j = 0; j < 4; j++) begin
                    a = bus_if.rvfi_mem_addr[r*32 +: 32] + 32'(j);
                    if (in_win(a)) begin
                        if (check && bus_if.rvfi_mem_rmask[r*4+j]) begin
                            n_cnt = (n_cnt < 65535) ? n_cnt + 1 : n_cnt;
                            n_hit = 1;
                            if (!n_mism && bus_if.rvfi_mem_rdata[r*32+8*j +: 8] != n_core[idx(a)]) begin
                                n_mism = 1; n_chan = 4'(r); n_addr = a;
                            end
                        end
                        if (bus_if.rvfi_mem_wmask[r*4+j])
                            n_core[idx(a)] = bus_if.rvfi_mem_wdata[r*32+8*j +: 8];
                    end
                end
            end
        end
`ifdef RISCV_FORMAL_BUS_DMEM_WRCHK_EN
        for (int c = 0; c < NBUS; c++) begin
            if (bus_if.rvfi_bus_valid[c] && bus_if.rvfi_bus_data[c]) begin
                for (int i = 0; i < 4; i++) begin
                    a = bus_if.rvfi_bus_addr[c*32 +: 32] + 32'(i);
                    if (in_win(a) && bus_if.rvfi_bus_wmask[c*4+i]) begin
                        n_hit = 1;
                        if (!n_mism && bus_if.rvfi_bus_wdata[c*32+8*i +: 8] != n_core[idx(a)]) begin
                            n_mism = 1; n_chan = 4'hF; n_addr = a;
                        end
                    end
                end
            end
        end
`endif
    endtask

    task automatic model_commit();
        if (m_fail) begin
            m_hit = 0;
        end else if (!m_run) begin
            m_run = 1; m_hit = 0;
        end else begin
            m_bus = n_bus; m_core = n_core; m_cnt = n_cnt; m_hit = n_hit;
            if (n_mism) begin
                m_err = 1; m_chan = n_chan; m_eaddr = n_addr;
                m_run = 0; m_fail = 1;
            end
        end
    endtask

    task automatic check_regs(input string tag);
        chk({tag, " err"}, 32'(err), 32'(m_err));
        chk({tag, " err_chan"}, 32'(err_chan), 32'(m_chan));
        chk({tag, " err_addr"}, err_addr, m_eaddr);
        chk({tag, " chk_count"}, 32'(chk_count), 32'(m_cnt));
        chk({tag, " cover_hit"}, 32'(cover_hit), 32'(m_hit));
    endtask

    // Entered at posedge+1 with inputs already driven; returns at posedge+1.
    task automatic cycle(input string tag);
        #3;
        model_eval();
        chk({tag, " env_ok"}, 32'(env_ok), 32'(e_env));
        @(posedge clock);
        #1;
        model_commit();
        check_regs(tag);
        txn++;
        $display("txn %0d %s env_ok=%0d err=%0d chan=%0h addr=%08h cnt=%0d hit=%0d",
                 txn, tag, e_env, err, err_chan, err_addr, chk_count, cover_hit);
    endtask

    task automatic idle();
        bus_if.rvfi_bus_valid = '0; bus_if.rvfi_bus_data = '0; bus_if.rvfi_bus_addr = '0;
        bus_if.rvfi_bus_rmask = '0; bus_if.rvfi_bus_wmask = '0;
        bus_if.rvfi_bus_rdata = '0; bus_if.rvfi_bus_wdata = '0;
        bus_if.rvfi_valid = '0; bus_if.rvfi_mem_addr = '0;
        bus_if.rvfi_mem_rmask = '0; bus_if.rvfi_mem_wmask = '0;
        bus_if.rvfi_mem_rdata = '0; bus_if.rvfi_mem_wdata = '0;
    endtask

    task automatic ret_op(input int ch, input logic [31:0] a, input logic [3:0] rm,
                          input logic [31:0] rd, input logic [3:0] wm, input logic [31:0] wd);
        bus_if.rvfi_valid[ch] = 1'b1;
        bus_if.rvfi_mem_addr[ch*32 +: 32] = a;
        bus_if.rvfi_mem_rmask[ch*4 +: 4] = rm;
        bus_if.rvfi_mem_rdata[ch*32 +: 32] = rd;
        bus_if.rvfi_mem_wmask[ch*4 +: 4] = wm;
        bus_if.rvfi_mem_wdata[ch*32 +: 32] = wd;
    endtask

    task automatic bus_op(input bit is_data, input logic [31:0] a, input logic [3:0] rm,
                          input logic [31:0] rd, input logic [3:0] wm, input logic [31:0] wd);
        bus_if.rvfi_bus_valid[0] = 1'b1;
        bus_if.rvfi_bus_data[0] = is_data;
        bus_if.rvfi_bus_addr[31:0] = a;
        bus_if.rvfi_bus_rmask[3:0] = rm;
        bus_if.rvfi_bus_rdata[31:0] = rd;
        bus_if.rvfi_bus_wmask[3:0] = wm;
        bus_if.rvfi_bus_wdata[31:0] = wd;
    endtask

    // Assert reset mid-cycle (posedge+1), check asynchronous clear, hold one edge.
    task automatic pulse_reset(input logic [31:0] base, input logic [31:0] init, input string tag);
        win_base = base;
        init_data = init;
        reset = 1'b1;
        #1;
        model_reset();
        check_regs(tag);
        @(posedge clock);
        #1;
        reset = 1'b0;
        idle();
    endtask

    // Plausible read data: model contents for in-window bytes, occasionally corrupted.
    function automatic logic [31:0] gen_rdata(input logic [31:0] a, input bit core_side);
        logic [31:0] d;
        d = $urandom;
        for (int j = 0; j < 4; j++)
            if (in_win(a + 32'(j)))
                d[8*j +: 8] = core_side ? m_core[idx(a + 32'(j))] : m_bus[idx(a + 32'(j))];
        if ($urandom_range(0, 29) == 0)
            d = d ^ (32'h1 << (8 * $urandom_range(0, 3)));
        return d;
    endfunction

    task automatic random_phase(input int n, input string tag);
        logic [31:0] a;
        for (int t = 0; t < n; t++) begin
            idle();
            check = ($urandom_range(0, 7) != 0);
            for (int ch = 0; ch < NRET; ch++) begin
                if ($urandom_range(0, 1) == 1) begin
                    a = base_al() + 32'($urandom_range(0, 23)) - 32'd4;
                    ret_op(ch, a, 4'($urandom), gen_rdata(a, 1'b1),
                           ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'h0, $urandom);
                end
            end
            if ($urandom_range(0, 1) == 1) begin
                a = base_al() + 32'($urandom_range(0, 23)) - 32'd4;
                bus_op($urandom_range(0, 3) != 0, a, 4'($urandom), gen_rdata(a, 1'b0),
                       ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'h0, $urandom);
            end
            cycle(tag);
            if (t % 75 == 74)
                pulse_reset(win_base, $urandom, {tag, " reset"});
        end
    endtask

    initial begin
        reset = 1'b1;
        check = 1'b0;
        win_base = 32'h0000_1000;
        init_data = 32'hA5A5_A5A5;
        idle();
        model_reset();
        repeat (2) @(posedge clock);
        #1;
        check_regs("reset state");
        reset = 1'b0;

        // First edge after reset is spent leaving INIT.
        cycle("init");
        check = 1'b1;

        idle(); ret_op(0, 32'h1004, 4'hF, 32'hA5A5_A5A5, 4'h0, 32'h0);
        cycle("tp1 load");
        chk("tp1 count const", 32'(chk_count), 32'd4);
        chk("tp1 hit const", 32'(cover_hit), 32'd1);
        idle();
        cycle("tp1 idle");
        chk("tp1 hit drop", 32'(cover_hit), 32'd0);

        idle(); bus_op(1'b1, 32'h1008, 4'hF, 32'h0, 4'h0, 32'h0);
        cycle("tp2 bad bus read");
        chk("tp2 env low", 32'(env_ok), 32'd0);
        idle(); bus_op(1'b1, 32'h1008, 4'hF, 32'hA5A5_A5A5, 4'h0, 32'h0);
        cycle("tp2 good bus read");
        chk("tp2 env high", 32'(env_ok), 32'd1);

        idle(); ret_op(0, 32'h100C, 4'h0, 32'h0, 4'hF, 32'h1122_3344);
        cycle("tp3 store");
        idle(); ret_op(1, 32'h100E, 4'hF, 32'hA5A5_1122, 4'h0, 32'h0);
        cycle("tp3 misaligned load");
        chk("tp3 count const", 32'(chk_count), 32'd6);
        chk("tp3 err const", 32'(err), 32'd0);

        idle();
        ret_op(0, 32'h1000, 4'hF, 32'hA5A5_00A5, 4'h0, 32'h0);
        ret_op(1, 32'h1004, 4'hF, 32'h0, 4'h0, 32'h0);
        cycle("tp4 double mismatch");
        chk("tp4 err const", 32'(err), 32'd1);
        chk("tp4 chan const", 32'(err_chan), 32'd0);
        chk("tp4 addr const", err_addr, 32'h1001);
        idle();
        ret_op(1, 32'h1008, 4'hF, 32'h0, 4'h0, 32'h0);
        cycle("tp4 later mismatch");
        chk("tp4 addr held", err_addr, 32'h1001);
        chk("tp4 count frozen", 32'(chk_count), 32'd14);

        pulse_reset(32'h1000, 32'hA5A5_A5A5, "tp5 reset");
        chk("tp5 err cleared", 32'(err), 32'd0);
        chk("tp5 count cleared", 32'(chk_count), 32'd0);
        cycle("tp5 init");
        ret_op(0, 32'h1000, 4'hF, 32'hA5A5_A5A5, 4'h0, 32'h0);
        cycle("tp5 load");
        chk("tp5 err after", 32'(err), 32'd0);
        chk("tp5 count after", 32'(chk_count), 32'd4);

        random_phase(300, "rnd");

        // Window straddling the top of the address space; low base bits ignored.
        pulse_reset(32'hFFFF_FFFA, $urandom, "wrap reset");
        random_phase(200, "wrap");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
